dense_par: RTL and testbench

- Fully-connected layer engine; the next generation of the single-lane dense block.
- Computes PAR output neurons in parallel, one lane per neuron.
- Streams the input vector from an external LAT-latency BRAM at one element per cycle, with no per-element wait states.
- Adds optional round-half-up, optional ReLU, and a per-group output strobe. Sits between the conv/pool feature-map buffer and the classifier/argmax stage.

---
 rtl/dense_par.sv | 204 ++++++++++++++++++++
 tb/tb_dense_par.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_par.sv
// Fully-connected layer engine: PAR lanes, each producing one output neuron per group,
// streaming the input vector from a LAT-latency BRAM at one element per cycle.
module dense_par #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 7,
    parameter int IN_DIM     = 1568,
    parameter int OUT_DIM    = 10,
    parameter int PAR        = 2,
    parameter int POST_SHIFT = 2,
    parameter int LAT        = 2,
    parameter int ROUND      = 0,
    parameter int RELU       = 0,
    // Row-major weight image W[o*IN_DIM+i] and bias image B[o]; element n sits at bits [n*DATA_WIDTH +: DATA_WIDTH].
    parameter logic [OUT_DIM*IN_DIM*DATA_WIDTH-1:0] WEIGHTS = '0,
    parameter logic [OUT_DIM*DATA_WIDTH-1:0]        BIASES  = '0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    output logic [$clog2(IN_DIM)-1:0]               in_addr,
    output logic                                    in_en,
    input  logic signed [DATA_WIDTH-1:0]            in_q,
    output logic signed [OUT_DIM-1:0][DATA_WIDTH-1:0] out_vec,
    output logic                                    out_valid,
    output logic [$clog2(OUT_DIM):0]                out_base,
    output logic                                    busy,
    output logic                                    done
);
    localparam int AW   = $clog2(IN_DIM);
    localparam int BW   = $clog2(OUT_DIM) + 1;
    localparam int G    = (OUT_DIM + PAR - 1) / PAR;
    localparam int ACCW = 2 * DATA_WIDTH + $clog2(IN_DIM) + 2;
    localparam int SH   = FRAC_BITS + POST_SHIFT;
    localparam int DCW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef logic signed [ACCW-1:0]       acc_t;
    typedef logic signed [DATA_WIDTH-1:0] data_t;

    localparam acc_t RND     = acc_t'(ROUND != 0 && SH > 0) << ((SH > 0) ? SH - 1 : 0);
    localparam acc_t SAT_MAX = acc_t'({(DATA_WIDTH-1){1'b1}});
    localparam acc_t SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_WRITE, S_FINISH} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   i_q, i_d;
    logic [DCW-1:0]  d_q, d_d;
    logic [BW-1:0]   g_q, g_d;
    logic [BW-1:0]   load_g;
    logic            load_bias;
    acc_t            acc_q [PAR];
    acc_t            acc_d [PAR];
    acc_t            b_load [PAR];
    data_t           w_cur [PAR];
    data_t           w_del [PAR];
    logic signed [2*DATA_WIDTH-1:0] prod [PAR];
    data_t           res [PAR];
    logic            tag_out;
    logic [OUT_DIM-1:0][DATA_WIDTH-1:0] out_q;
    logic            valid_q;
    logic [BW-1:0]   base_q;

    // Lanes whose neuron index falls past OUT_DIM read zero and never touch the images.
    always_comb begin
        for (int l = 0; l < PAR; l++) begin
            int o_w;
            int o_b;
            o_w = int'(g_q) * PAR + l;
            o_b = int'(load_g) * PAR + l;
            w_cur[l]  = '0;
            b_load[l] = '0;
            if (o_w < OUT_DIM)
                w_cur[l] = WEIGHTS[(o_w * IN_DIM + int'(i_q)) * DATA_WIDTH +: DATA_WIDTH];
            if (o_b < OUT_DIM)
                b_load[l] = acc_t'($signed(BIASES[o_b * DATA_WIDTH +: DATA_WIDTH])) <<< FRAC_BITS;
        end
    end

    if (LAT == 0) begin : g_lat0
        always_comb begin
            tag_out = (state_q == S_STREAM);
            w_del   = w_cur;
        end
    end else begin : g_latn
        logic  tag_q [LAT];
        data_t w_pipe_q [LAT][PAR];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j < LAT; j++) begin
                    tag_q[j] <= 1'b0;
                    for (int l = 0; l < PAR; l++) w_pipe_q[j][l] <= '0;
                end
            end else begin
                tag_q[0]    <= (state_q == S_STREAM);
                w_pipe_q[0] <= w_cur;
                for (int j = 1; j < LAT; j++) begin
                    tag_q[j]    <= tag_q[j-1];
                    w_pipe_q[j] <= w_pipe_q[j-1];
                end
            end
        end

        always_comb begin
            tag_out = tag_q[LAT-1];
            w_del   = w_pipe_q[LAT-1];
        end
    end

    always_comb begin
        for (int l = 0; l < PAR; l++) begin
            acc_t sum;
            acc_t shr;
            prod[l]  = in_q * w_del[l];
            acc_d[l] = acc_q[l];
            if (load_bias)
                acc_d[l] = b_load[l];
            else if (tag_out)
                acc_d[l] = acc_q[l] + acc_t'(prod[l]);
            sum    = acc_q[l] + RND;
            shr    = sum >>> SH;
            res[l] = shr[DATA_WIDTH-1:0];
            if (shr > SAT_MAX)
                res[l] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            else if (shr < SAT_MIN)
                res[l] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            if (RELU != 0 && res[l][DATA_WIDTH-1])
                res[l] = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        d_d       = d_q;
        g_d       = g_q;
        load_bias = 1'b0;
        load_g    = '0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_STREAM;
                i_d       = '0;
                g_d       = '0;
                load_bias = 1'b1;
            end
            S_STREAM: begin
                i_d = i_q + AW'(1);
                if (i_q == AW'(IN_DIM - 1)) begin
                    i_d     = '0;
                    d_d     = '0;
                    state_d = (LAT == 0) ? S_WRITE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                d_d = d_q + DCW'(1);
                if (d_q == DCW'(LAT - 1)) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (g_q == BW'(G - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d   = S_STREAM;
                    g_d       = g_q + BW'(1);
                    load_g    = g_q + BW'(1);
                    load_bias = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            d_q     <= '0;
            g_q     <= '0;
            for (int l = 0; l < PAR; l++) acc_q[l] <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            d_q     <= d_d;
            g_q     <= g_d;
            acc_q   <= acc_d;
            valid_q <= (state_q == S_WRITE);
            if (state_q == S_WRITE) base_q <= BW'(int'(g_q) * PAR);
            // Neuron o always belongs to group o/PAR, lane o%PAR.
            for (int o = 0; o < OUT_DIM; o++)
                if (state_q == S_WRITE && int'(g_q) == o / PAR) out_q[o] <= res[o % PAR];
        end
    end

    assign in_en     = (state_q == S_STREAM);
    assign in_addr   = i_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign out_vec   = out_q;
    assign out_valid = valid_q;
    assign out_base  = base_q;
endmodule

// File: tb/tb_dense_par.sv
// Bench for dense_par: seven small instances (LAT sweep, saturation, rounding, ReLU) share one
// input vector; each has its own BRAM model of matching latency.
module tb_dense_par;
    localparam int NK = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [15:0] mem [4];

    logic [2:0][15:0] vec_all   [NK];
    logic             busy_all  [NK];
    logic             done_all  [NK];
    logic             valid_all [NK];
    logic             en_all    [NK];
    logic [2:0]       base_all  [NK];
    logic [1:0]       addr_all  [NK];

    int checks   = 0;
    int failures = 0;

    // Instance configuration: 0..3 share the basic weights with LAT 2,0,1,3; 4..6 use the extreme weights.
    function automatic int lat_of(input int k);
        case (k)
            1: return 0;
            2: return 1;
            3: return 3;
            default: return 2;
        endcase
    endfunction
    function automatic int rnd_of(input int k);  return (k == 5) ? 1 : 0; endfunction
    function automatic int relu_of(input int k); return (k == 6) ? 1 : 0; endfunction
    function automatic int w_val(input int k, input int o);
        if (k < 4) return 128;
        if (o == 0) return 32767;
        if (o == 1) return -32768;
        return 64;
    endfunction
    function automatic int b_val(input int k, input int o);
        if (k < 4) return (o == 0) ? 0 : (o == 1) ? 3 : -2;
        return (o == 0) ? -5 : 0;
    endfunction
    function automatic logic [191:0] make_w(input int k);
        logic [191:0] r;
        r = '0;
        for (int o = 0; o < 3; o++)
            for (int i = 0; i < 4; i++) r[(o*4+i)*16 +: 16] = 16'(w_val(k, o));
        return r;
    endfunction
    function automatic logic [47:0] make_b(input int k);
        logic [47:0] r;
        r = '0;
        for (int o = 0; o < 3; o++) r[o*16 +: 16] = 16'(b_val(k, o));
        return r;
    endfunction

    for (genvar k = 0; k < NK; k++) begin : g_dut
        localparam int LK = lat_of(k);
        localparam logic [191:0] WK = make_w(k);
        localparam logic [47:0]  BK = make_b(k);
        logic [1:0]       addr;
        logic             en, busy, done, valid;
        logic [2:0]       base;
        logic [2:0][15:0] vec;
        logic [15:0]      q0, qin;

        assign q0 = en ? mem[addr] : 16'hDEAD;
        if (LK == 0) begin : g_comb
            assign qin = q0;
        end else begin : g_pipe
            logic [15:0] pipe [LK];
            always @(posedge clk) begin
                pipe[0] <= q0;
                for (int j = 1; j < LK; j++) pipe[j] <= pipe[j-1];
            end
            assign qin = pipe[LK-1];
        end

        dense_par #(
            .DATA_WIDTH(16), .FRAC_BITS(7), .IN_DIM(4), .OUT_DIM(3), .PAR(2),
            .POST_SHIFT(0), .LAT(LK), .ROUND(rnd_of(k)), .RELU(relu_of(k)),
            .WEIGHTS(WK), .BIASES(BK)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start),
            .in_addr(addr), .in_en(en), .in_q(qin),
            .out_vec(vec), .out_valid(valid), .out_base(base),
            .busy(busy), .done(done)
        );

        assign vec_all[k]   = vec;
        assign busy_all[k]  = busy;
        assign done_all[k]  = done;
        assign valid_all[k] = valid;
        assign en_all[k]    = en;
        assign base_all[k]  = base;
        assign addr_all[k]  = addr;
    end

    typedef struct packed {
        logic [3:0][15:0] in_v;
        logic [2:0][15:0] eb;
        logic [2:0][15:0] es;
        logic [2:0][15:0] er;
        logic [2:0][15:0] el;
    } vec_t;
    vec_t tbl [5];

    function automatic vec_t mk(input int a0, a1, a2, a3, e0, e1, e2, s0, s1, s2,
                                input int r0, r1, r2, l0, l1, l2);
        vec_t t;
        t.in_v[0] = 16'(a0); t.in_v[1] = 16'(a1); t.in_v[2] = 16'(a2); t.in_v[3] = 16'(a3);
        t.eb[0] = 16'(e0); t.eb[1] = 16'(e1); t.eb[2] = 16'(e2);
        t.es[0] = 16'(s0); t.es[1] = 16'(s1); t.es[2] = 16'(s2);
        t.er[0] = 16'(r0); t.er[1] = 16'(r1); t.er[2] = 16'(r2);
        t.el[0] = 16'(l0); t.el[1] = 16'(l1); t.el[2] = 16'(l2);
        return t;
    endfunction

    function automatic logic [2:0][15:0] exp_of(input vec_t t, input int k);
        if (k < 4) return t.eb;
        if (k == 4) return t.es;
        if (k == 5) return t.er;
        return t.el;
    endfunction

    // Reference: exact integer dot product, floor shift, clamp, optional ReLU.
    function automatic int model(input int k, input int o);
        longint acc;
        longint r;
        acc = longint'(b_val(k, o)) * 128;
        for (int i = 0; i < 4; i++) acc += longint'($signed(mem[i])) * longint'(w_val(k, o));
        if (rnd_of(k) != 0) acc += 64;
        r = acc >>> 7;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu_of(k) != 0 && r < 0) r = 0;
        return int'(r);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input vec_t t);
        for (int i = 0; i < 4; i++) mem[i] = t.in_v[i];
    endtask

    // Start a layer and watch every instance for 40 cycles; cycle 0 is the start-sampling edge.
    task automatic run_layer(input string tag, input int extra_c);
        int dc [NK]; int dn [NK]; int vn [NK];
        int vc0 [NK]; int vc1 [NK]; int vb0 [NK]; int vb1 [NK];
        for (int k = 0; k < NK; k++) begin
            dc[k] = -1; dn[k] = 0; vn[k] = 0; vc0[k] = -1; vc1[k] = -1; vb0[k] = -1; vb1[k] = -1;
        end
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1 || c == extra_c + 1) start = 1'b0;
            if (c == extra_c) start = 1'b1;
            for (int k = 0; k < NK; k++) begin
                if (c == 1) chk($sformatf("%s_busy_c1_k%0d", tag, k), longint'(busy_all[k]), 1);
                if (done_all[k]) begin
                    dn[k]++;
                    if (dc[k] < 0) dc[k] = c;
                end
                if (valid_all[k]) begin
                    if (vn[k] == 0) begin vc0[k] = c; vb0[k] = int'(base_all[k]); end
                    if (vn[k] == 1) begin vc1[k] = c; vb1[k] = int'(base_all[k]); end
                    vn[k]++;
                end
            end
        end
        for (int k = 0; k < NK; k++) begin
            int lk;
            lk = lat_of(k);
            chk($sformatf("%s_done_cycle_k%0d", tag, k), dc[k], 1 + 2 * (4 + lk + 1));
            chk($sformatf("%s_done_pulses_k%0d", tag, k), dn[k], 1);
            chk($sformatf("%s_valid_pulses_k%0d", tag, k), vn[k], 2);
            chk($sformatf("%s_valid0_cycle_k%0d", tag, k), vc0[k], 1 + (4 + lk + 1));
            chk($sformatf("%s_base0_k%0d", tag, k), vb0[k], 0);
            chk($sformatf("%s_valid1_cycle_k%0d", tag, k), vc1[k], 1 + 2 * (4 + lk + 1));
            chk($sformatf("%s_base1_k%0d", tag, k), vb1[k], 2);
            chk($sformatf("%s_busy_end_k%0d", tag, k), longint'(busy_all[k]), 0);
        end
    endtask

    task automatic check_table_row(input string tag, input vec_t t);
        logic [2:0][15:0] e;
        for (int k = 0; k < NK; k++) begin
            e = exp_of(t, k);
            for (int o = 0; o < 3; o++)
                chk($sformatf("%s_vec_k%0d_o%0d", tag, k, o),
                    longint'($signed(vec_all[k][o])), longint'($signed(e[o])));
        end
    endtask

    initial begin
        tbl[0] = mk(128, 128, 128, 128,        512, 515, 510,
                    32767, -32768, 256,        32767, -32768, 256,     32767, 0, 256);
        tbl[1] = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767,
                    32767, -32768, 32767,      32767, -32768, 32767,   32767, 0, 32767);
        tbl[2] = mk(1, 0, 0, 0,                1, 4, -1,
                    250, -256, 0,              251, -256, 1,           250, 0, 0);
        tbl[3] = mk(0, 0, 0, 0,                0, 3, -2,
                    -5, 0, 0,                  -5, 0, 0,               0, 0, 0);
        tbl[4] = mk(-128, 256, -32768, 5,      -32635, -32632, -32637,
                    -32768, 32767, -16318,     -32768, 32767, -16317,  0, 32767, 0);

        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("rst_busy_k%0d", k),  longint'(busy_all[k]), 0);
            chk($sformatf("rst_done_k%0d", k),  longint'(done_all[k]), 0);
            chk($sformatf("rst_valid_k%0d", k), longint'(valid_all[k]), 0);
            chk($sformatf("rst_en_k%0d", k),    longint'(en_all[k]), 0);
            chk($sformatf("rst_addr_k%0d", k),  longint'(addr_all[k]), 0);
            chk($sformatf("rst_base_k%0d", k),  longint'(base_all[k]), 0);
            for (int o = 0; o < 3; o++)
                chk($sformatf("rst_vec_k%0d_o%0d", k, o), longint'(vec_all[k][o]), 0);
        end
        reset = 1'b0;

        for (int n = 0; n < 5; n++) begin
            load_mem(tbl[n]);
            run_layer($sformatf("tbl%0d", n), -1);
            check_table_row($sformatf("tbl%0d", n), tbl[n]);
        end
        repeat (5) @(negedge clk);
        check_table_row("hold", tbl[4]);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 4; i++)
                if (r < 5) mem[i] = 16'($urandom_range(0, 65535));
                else mem[i] = 16'(int'($urandom_range(0, 600)) - 300);
            run_layer($sformatf("rnd%0d", r), -1);
            for (int k = 0; k < NK; k++)
                for (int o = 0; o < 3; o++)
                    chk($sformatf("rnd%0d_vec_k%0d_o%0d", r, k, o),
                        longint'($signed(vec_all[k][o])), longint'(model(k, o)));
        end

        load_mem(tbl[0]);
        run_layer("midstart", 3);
        check_table_row("midstart", tbl[0]);

        // Abort during the second group's stream for every latency.
        load_mem(tbl[4]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("abort_busy_k%0d", k),  longint'(busy_all[k]), 0);
            chk($sformatf("abort_en_k%0d", k),    longint'(en_all[k]), 0);
            chk($sformatf("abort_valid_k%0d", k), longint'(valid_all[k]), 0);
            chk($sformatf("abort_done_k%0d", k),  longint'(done_all[k]), 0);
            for (int o = 0; o < 3; o++)
                chk($sformatf("abort_vec_k%0d_o%0d", k, o), longint'(vec_all[k][o]), 0);
        end
        reset = 1'b0;
        load_mem(tbl[0]);
        run_layer("restart", -1);
        check_table_row("restart", tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
